// File: rtl/voice_allocator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : voice_allocator_pkg                                            |
// | Purpose   : Shared sizing constants and FSM state encoding for the         |
// |             polyphonic voice allocator and its age/key table.              |
// | Contents  : VOICES, V_WIDTH, AGE_W, KEY_W, alloc_state_t                   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package voice_allocator_pkg;

  localparam int VOICES  = 8;   // number of synth voices
  localparam int V_WIDTH = 3;   // log2(VOICES), voice index width
  localparam int AGE_W   = 8;   // saturating per-voice age counter width
  localparam int KEY_W   = 8;   // MIDI key / velocity byte width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HOLD  = 2'd3
  } alloc_state_t;

endpackage
`default_nettype wire

// File: rtl/voice_age_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : voice_age_table                                                |
// | Purpose   : Per-voice key table and saturating age counters.               |
// |             One combinational indexed read port used while scanning, one   |
// |             assign port: the target voice takes the new key with age 0     |
// |             while every other voice ages by one (saturating).              |
// | Ports     : clk, rst_n        clock / async active-low reset               |
// |             rd_idx            voice to read                                |
// |             rd_key, rd_age    key and age of voice rd_idx                  |
// |             wr_en             assign strobe (one per note-on)              |
// |             wr_idx, wr_key    voice being assigned and its new key         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module voice_age_table
  import voice_allocator_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [V_WIDTH-1:0] rd_idx,
  output logic [KEY_W-1:0]   rd_key,
  output logic [AGE_W-1:0]   rd_age,
  input  logic               wr_en,
  input  logic [V_WIDTH-1:0] wr_idx,
  input  logic [KEY_W-1:0]   wr_key
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [KEY_W-1:0] r_key_tab [VOICES];
  logic [AGE_W-1:0] r_age     [VOICES];

  assign rd_key = r_key_tab[rd_idx];
  assign rd_age = r_age[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        r_key_tab[i] <= '0;
        r_age[i]     <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < VOICES; i++) begin
        if (wr_idx == V_WIDTH'(i)) begin
          r_key_tab[i] <= wr_key;
          r_age[i]     <= '0;
        end else if (r_age[i] != AGE_MAX) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : voice_allocator                                                |
// | Purpose   : Polyphonic voice scheduler between the MIDI decoder and the    |
// |             synth engine. Note-on goes to: retriggered voice, else a free  |
// |             voice, else the oldest released voice, else the oldest held    |
// |             voice (steal). Results are held until the engine frame latch.  |
// | Ports     : OSC_CLK, iRST_N          clock / async active-low reset        |
// |             evt_valid/evt_ready      note event handshake                  |
// |             evt_on, evt_key, evt_vel note event payload                    |
// |             all_off                  panic, releases every voice in IDLE   |
// |             voice_free               envelope idle flag per voice          |
// |             n_xxxx_zero              async frame strobe, active low        |
// |             keys_on                  held-key level per voice              |
// |             note_on                  new-note strobe held until latch      |
// |             cur_key_adr/val          target voice / key of last event      |
// |             cur_vel_on/off           note-on / note-off velocity           |
// |             steal, drop              1-cycle status pulses                 |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module voice_allocator
  import voice_allocator_pkg::*;
(
  input  logic               OSC_CLK,
  input  logic               iRST_N,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic               evt_on,
  input  logic [KEY_W-1:0]   evt_key,
  input  logic [KEY_W-1:0]   evt_vel,
  input  logic               all_off,
  input  logic [VOICES-1:0]  voice_free,
  input  logic               n_xxxx_zero,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [KEY_W-1:0]   cur_key_val,
  output logic [KEY_W-1:0]   cur_vel_on,
  output logic [KEY_W-1:0]   cur_vel_off,
  output logic               steal,
  output logic               drop
);

  alloc_state_t r_state, w_next_state;

  // latched event
  logic [KEY_W-1:0]   r_key, r_vel;
  logic               r_is_on;

  // scan bookkeeping
  logic [V_WIDTH-1:0] r_idx;
  logic               r_match_hit, r_free_hit, r_rel_hit, r_held_hit;
  logic [V_WIDTH-1:0] r_match_idx, r_free_idx, r_rel_idx, r_held_idx;
  logic [AGE_W-1:0]   r_rel_age, r_held_age;

  // frame strobe synchroniser plus one delay stage for edge detection
  logic               r_sync1, r_sync2, r_sync3;

  logic [KEY_W-1:0]   w_rd_key;
  logic [AGE_W-1:0]   w_rd_age;
  logic               w_accept, w_last, w_cur_held, w_cur_free, w_frame_fall;
  logic               w_do_assign, w_do_release, w_do_steal, w_do_drop;
  logic [V_WIDTH-1:0] w_target;

  assign w_accept     = evt_valid && evt_ready;
  assign w_last       = (r_idx == V_WIDTH'(VOICES - 1));
  assign w_cur_held   = keys_on[r_idx];
  assign w_cur_free   = voice_free[r_idx] && !keys_on[r_idx];
  assign w_frame_fall = r_sync3 && !r_sync2;

  voice_age_table u_age_table (
    .clk    (OSC_CLK),
    .rst_n  (iRST_N),
    .rd_idx (r_idx),
    .rd_key (w_rd_key),
    .rd_age (w_rd_age),
    .wr_en  (w_do_assign),
    .wr_idx (w_target),
    .wr_key (r_key)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    evt_ready    = 1'b0;
    w_target     = r_held_idx;
    w_do_assign  = 1'b0;
    w_do_release = 1'b0;
    w_do_steal   = 1'b0;
    w_do_drop    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        evt_ready = !all_off;
        if (evt_valid && !all_off) w_next_state = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_last) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (r_is_on) begin
          w_do_assign  = 1'b1;
          w_next_state = ST_HOLD;
          if (r_match_hit)     w_target = r_match_idx;
          else if (r_free_hit) w_target = r_free_idx;
          else if (r_rel_hit)  w_target = r_rel_idx;
          else begin
            // every voice is held: take the longest-held one
            w_target   = r_held_idx;
            w_do_steal = 1'b1;
          end
        end else begin
          w_next_state = ST_IDLE;
          if (r_match_hit) begin
            w_target     = r_match_idx;
            w_do_release = 1'b1;
          end else begin
            w_do_drop = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_frame_fall) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- event latch and scan
  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_key       <= '0;
      r_vel       <= '0;
      r_is_on     <= 1'b0;
      r_idx       <= '0;
      r_match_hit <= 1'b0;
      r_free_hit  <= 1'b0;
      r_rel_hit   <= 1'b0;
      r_held_hit  <= 1'b0;
      r_match_idx <= '0;
      r_free_idx  <= '0;
      r_rel_idx   <= '0;
      r_held_idx  <= '0;
      r_rel_age   <= '0;
      r_held_age  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_key       <= evt_key;
            r_vel       <= evt_vel;
            // a zero-velocity note-on is a note-off
            r_is_on     <= evt_on && (evt_vel != '0);
            r_idx       <= '0;
            r_match_hit <= 1'b0;
            r_free_hit  <= 1'b0;
            r_rel_hit   <= 1'b0;
            r_held_hit  <= 1'b0;
          end
        end
        ST_SCAN: begin
          r_idx <= r_idx + 1'b1;
          if (w_cur_held && (w_rd_key == r_key) && !r_match_hit) begin
            r_match_hit <= 1'b1;
            r_match_idx <= r_idx;
          end
          if (w_cur_free && !r_free_hit) begin
            r_free_hit <= 1'b1;
            r_free_idx <= r_idx;
          end
          // strict compare while scanning upward keeps ties on the lower index
          if (!w_cur_held && (!r_rel_hit || (w_rd_age > r_rel_age))) begin
            r_rel_hit <= 1'b1;
            r_rel_idx <= r_idx;
            r_rel_age <= w_rd_age;
          end
          if (w_cur_held && (!r_held_hit || (w_rd_age > r_held_age))) begin
            r_held_hit <= 1'b1;
            r_held_idx <= r_idx;
            r_held_age <= w_rd_age;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------- frame synchroniser
  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      // strobe idles high; resetting high avoids a false fall after reset
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= n_xxxx_zero;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // ---------------------------------------------------- output registers
  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      keys_on     <= '0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      steal       <= 1'b0;
      drop        <= 1'b0;
    end else begin
      steal <= w_do_steal;
      drop  <= w_do_drop;
      if ((r_state == ST_IDLE) && all_off) keys_on <= '0;
      if (w_do_assign) begin
        keys_on[w_target] <= 1'b1;
        cur_key_adr       <= w_target;
        cur_key_val       <= r_key;
        cur_vel_on        <= r_vel;
        note_on           <= 1'b1;
      end
      if (w_do_release) begin
        keys_on[w_target] <= 1'b0;
        cur_key_adr       <= w_target;
        cur_key_val       <= r_key;
        cur_vel_off       <= r_vel;
      end
      // only a fall seen while holding releases the strobe, so an edge
      // arriving during scan/issue never cuts note_on short
      if ((r_state == ST_HOLD) && w_frame_fall) note_on <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_voice_allocator                                             |
// | Purpose   : Self-checking bench for voice_allocator. A behavioural model   |
// |             of the voice table (held flag, key, age per voice) predicts    |
// |             every event outcome; scenarios plus a randomized run.          |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  logic       OSC_CLK = 1'b0;
  logic       iRST_N  = 1'b0;
  logic       evt_valid = 1'b0;
  logic       evt_ready;
  logic       evt_on = 1'b0;
  logic [7:0] evt_key = '0;
  logic [7:0] evt_vel = '0;
  logic       all_off = 1'b0;
  logic [7:0] voice_free = 8'hFF;
  logic       n_xxxx_zero = 1'b1;
  logic [7:0] keys_on;
  logic       note_on;
  logic [2:0] cur_key_adr;
  logic [7:0] cur_key_val, cur_vel_on, cur_vel_off;
  logic       steal, drop;

  voice_allocator dut (
    .OSC_CLK     (OSC_CLK),
    .iRST_N      (iRST_N),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_on      (evt_on),
    .evt_key     (evt_key),
    .evt_vel     (evt_vel),
    .all_off     (all_off),
    .voice_free  (voice_free),
    .n_xxxx_zero (n_xxxx_zero),
    .keys_on     (keys_on),
    .note_on     (note_on),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .cur_vel_off (cur_vel_off),
    .steal       (steal),
    .drop        (drop)
  );

  always #5 OSC_CLK = ~OSC_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model of the voice pool
  bit         m_on  [8];
  logic [7:0] m_key [8];
  int         m_age [8];
  logic [2:0] m_adr;
  logic [7:0] m_val, m_von, m_voff;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_on[i] = 1'b0; m_key[i] = '0; m_age[i] = 0;
    end
    m_adr = '0; m_val = '0; m_von = '0; m_voff = '0;
  endfunction

  function automatic logic [7:0] model_keys();
    logic [7:0] k;
    for (int i = 0; i < 8; i++) k[i] = m_on[i];
    return k;
  endfunction

  function automatic int find_match(input logic [7:0] key);
    for (int i = 0; i < 8; i++) if (m_on[i] && m_key[i] == key) return i;
    return -1;
  endfunction

  // voice with the greatest age among voices whose held flag equals 'held',
  // lowest index among equals; -1 if there is none
  function automatic int oldest(input bit held);
    int best = -1;
    for (int i = 0; i < 8; i++) if (m_on[i] == held && m_age[i] > best) best = m_age[i];
    if (best < 0) return -1;
    for (int i = 0; i < 8; i++) if (m_on[i] == held && m_age[i] == best) return i;
    return -1;
  endfunction

  function automatic int pick_target(input logic [7:0] key, input logic [7:0] free,
                                     output bit stolen);
    int t;
    stolen = 1'b0;
    t = find_match(key);
    if (t >= 0) return t;
    for (int i = 0; i < 8; i++) if (free[i] && !m_on[i]) return i;
    t = oldest(1'b0);
    if (t >= 0) return t;
    stolen = 1'b1;
    return oldest(1'b1);
  endfunction

  // drive an event at a falling edge and let the next rising edge accept it
  task automatic accept_event(input bit on, input logic [7:0] key, input logic [7:0] vel,
                              input logic [7:0] free);
    evt_valid = 1'b1; evt_on = on; evt_key = key; evt_vel = vel; voice_free = free;
    #1;
    n_tests++;
    if (evt_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_ready: got %b want 1", evt_ready);
    end
    @(posedge OSC_CLK);
  endtask

  // called right after the accept edge; checks latency, results and hold
  task automatic check_event(input bit on, input logic [7:0] key, input logic [7:0] vel,
                             input logic [7:0] free, input bit frame_in_scan);
    bit eff_on;
    bit exp_steal, exp_drop;
    int t;
    eff_on    = on && (vel != 8'd0);
    exp_steal = 1'b0;
    exp_drop  = 1'b0;
    if (eff_on) begin
      t = pick_target(key, free, exp_steal);
      for (int i = 0; i < 8; i++) if (i != t && m_age[i] < 255) m_age[i]++;
      m_on[t] = 1'b1; m_key[t] = key; m_age[t] = 0;
      m_adr = 3'(t); m_val = key; m_von = vel;
    end else begin
      t = find_match(key);
      if (t < 0) exp_drop = 1'b1;
      else begin
        m_on[t] = 1'b0; m_adr = 3'(t); m_val = key; m_voff = vel;
      end
    end
    @(negedge OSC_CLK);                     // cycle k+1
    evt_valid = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge OSC_CLK);
      if (frame_in_scan) n_xxxx_zero = !(c >= 2 && c <= 4);
    end
    // cycle k+9: still issuing
    n_tests++;
    if (note_on !== 1'b0 || evt_ready !== 1'b0) begin
      n_fail++; $display("FAIL early_k9: note_on=%b ready=%b want 0/0", note_on, evt_ready);
    end
    @(negedge OSC_CLK);                     // cycle k+10
    n_tests++;
    if (note_on !== eff_on) begin
      n_fail++; $display("FAIL note_on_k10 key%0d: got %b want %b", key, note_on, eff_on);
    end
    n_tests++;
    if (evt_ready !== !eff_on) begin
      n_fail++; $display("FAIL ready_k10 key%0d: got %b want %b", key, evt_ready, !eff_on);
    end
    n_tests++;
    if (keys_on !== model_keys()) begin
      n_fail++; $display("FAIL keys_on key%0d: got %h want %h", key, keys_on, model_keys());
    end
    n_tests++;
    if (cur_key_adr !== m_adr || cur_key_val !== m_val) begin
      n_fail++; $display("FAIL adr_val key%0d: got %0d/%0d want %0d/%0d",
                         key, cur_key_adr, cur_key_val, m_adr, m_val);
    end
    n_tests++;
    if (cur_vel_on !== m_von || cur_vel_off !== m_voff) begin
      n_fail++; $display("FAIL vel key%0d: got on=%0d off=%0d want on=%0d off=%0d",
                         key, cur_vel_on, cur_vel_off, m_von, m_voff);
    end
    n_tests++;
    if (steal !== exp_steal || drop !== exp_drop) begin
      n_fail++; $display("FAIL pulses key%0d: got steal=%b drop=%b want %b/%b",
                         key, steal, drop, exp_steal, exp_drop);
    end
    @(negedge OSC_CLK);                     // cycle k+11
    n_tests++;
    if (steal !== 1'b0 || drop !== 1'b0 || note_on !== eff_on) begin
      n_fail++; $display("FAIL k11: steal=%b drop=%b note_on=%b want 0/0/%b",
                         steal, drop, note_on, eff_on);
    end
    if (eff_on && frame_in_scan) begin
      repeat (4) @(negedge OSC_CLK);
      n_tests++;
      if (note_on !== 1'b1) begin
        n_fail++; $display("FAIL scan_edge_ignored: note_on=%b want 1", note_on);
      end
    end
    if (eff_on) begin
      n_xxxx_zero = 1'b0;                   // fall in cycle c
      repeat (2) @(negedge OSC_CLK);        // cycle c+2
      n_tests++;
      if (note_on !== 1'b1) begin
        n_fail++; $display("FAIL hold_c2: note_on=%b want 1", note_on);
      end
      @(negedge OSC_CLK);                   // cycle c+3
      n_tests++;
      if (note_on !== 1'b0 || evt_ready !== 1'b1) begin
        n_fail++; $display("FAIL release_c3: note_on=%b ready=%b want 0/1", note_on, evt_ready);
      end
      n_xxxx_zero = 1'b1;
      repeat (3) @(negedge OSC_CLK);
    end
  endtask

  task automatic run_event(input bit on, input logic [7:0] key, input logic [7:0] vel,
                           input logic [7:0] free);
    accept_event(on, key, vel, free);
    check_event(on, key, vel, free, 1'b0);
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    model_reset();
    repeat (2) @(negedge OSC_CLK);
    n_tests++;
    if (evt_ready !== 1'b1 || keys_on !== 8'h00 || note_on !== 1'b0 || steal !== 1'b0 ||
        drop !== 1'b0 || cur_key_adr !== 3'd0 || cur_key_val !== 8'd0 ||
        cur_vel_on !== 8'd0 || cur_vel_off !== 8'd0) begin
      n_fail++; $display("FAIL reset_state: ready=%b keys=%h note=%b adr=%0d val=%0d",
                         evt_ready, keys_on, note_on, cur_key_adr, cur_key_val);
    end
    iRST_N = 1'b1;
    @(negedge OSC_CLK);
    n_tests++;
    if (evt_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b want 1", evt_ready);
    end
  endtask

  task automatic test_note_on_basic();
    run_event(1'b1, 8'd60, 8'd100, 8'hFF);
    n_tests++;
    if (cur_key_adr !== 3'd0 || keys_on !== 8'h01 || cur_vel_on !== 8'd100) begin
      n_fail++; $display("FAIL first_on: adr=%0d keys=%h vel=%0d want 0/01/100",
                         cur_key_adr, keys_on, cur_vel_on);
    end
  endtask

  task automatic test_note_off_basic();
    run_event(1'b0, 8'd60, 8'd40, 8'hFF);
  endtask

  task automatic test_steal();
    for (int k = 60; k <= 67; k++) run_event(1'b1, 8'(k), 8'(k), 8'hFF);
    run_event(1'b1, 8'd70, 8'd55, 8'h00);
    n_tests++;
    if (cur_key_adr !== 3'd0 || keys_on !== 8'hFF || cur_key_val !== 8'd70) begin
      n_fail++; $display("FAIL steal_target: adr=%0d keys=%h val=%0d want 0/FF/70",
                         cur_key_adr, keys_on, cur_key_val);
    end
  endtask

  task automatic test_retrigger();
    run_event(1'b1, 8'd62, 8'd90, 8'hFF);
  endtask

  task automatic test_vel0_and_drop();
    run_event(1'b1, 8'd61, 8'd0, 8'hFF);
    run_event(1'b0, 8'd50, 8'd33, 8'hFF);
  endtask

  task automatic test_frame_during_scan();
    accept_event(1'b1, 8'd45, 8'd21, 8'hFF);
    check_event(1'b1, 8'd45, 8'd21, 8'hFF, 1'b1);
  endtask

  task automatic test_all_off();
    all_off = 1'b1; evt_valid = 1'b1; evt_on = 1'b1; evt_key = 8'd40; evt_vel = 8'd10;
    voice_free = 8'hFF;
    #1;
    n_tests++;
    if (evt_ready !== 1'b0) begin
      n_fail++; $display("FAIL all_off_ready: got %b want 0", evt_ready);
    end
    for (int i = 0; i < 8; i++) m_on[i] = 1'b0;
    @(negedge OSC_CLK);
    n_tests++;
    if (keys_on !== 8'h00) begin
      n_fail++; $display("FAIL all_off_keys: got %h want 00", keys_on);
    end
    all_off = 1'b0;
    #1;
    n_tests++;
    if (evt_ready !== 1'b1) begin
      n_fail++; $display("FAIL all_off_then_ready: got %b want 1", evt_ready);
    end
    @(posedge OSC_CLK);
    check_event(1'b1, 8'd40, 8'd10, 8'hFF, 1'b0);
  endtask

  task automatic test_random();
    bit on;
    logic [7:0] key, vel, free;
    for (int n = 0; n < 40; n++) begin
      on   = ($urandom_range(0, 2) != 0);
      key  = 8'($urandom_range(58, 69));
      vel  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
      free = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      run_event(on, key, vel, free);
    end
  endtask

  task automatic test_reset_in_hold();
    accept_event(1'b1, 8'd33, 8'd77, 8'hFF);
    @(negedge OSC_CLK);
    evt_valid = 1'b0;
    repeat (10) @(negedge OSC_CLK);
    n_tests++;
    if (note_on !== 1'b1 || evt_ready !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset_hold: note_on=%b ready=%b want 1/0", note_on, evt_ready);
    end
    iRST_N = 1'b0;
    #1;
    n_tests++;
    if (note_on !== 1'b0 || keys_on !== 8'h00 || cur_key_adr !== 3'd0 ||
        cur_key_val !== 8'd0 || cur_vel_on !== 8'd0 || cur_vel_off !== 8'd0 ||
        steal !== 1'b0 || drop !== 1'b0 || evt_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_hold: note=%b keys=%h adr=%0d val=%0d ready=%b",
                         note_on, keys_on, cur_key_adr, cur_key_val, evt_ready);
    end
    model_reset();
    @(negedge OSC_CLK);
    iRST_N = 1'b1;
    @(negedge OSC_CLK);
    run_event(1'b1, 8'd60, 8'd100, 8'hFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_note_on_basic();
    test_note_off_basic();
    test_steal();
    test_retrigger();
    test_vel0_and_drop();
    test_frame_during_scan();
    test_all_off();
    test_random();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
